// File: rtl/text_line_driver.sv
// text_line_driver: maps the VGA scan position onto one line of character
// cells and feeds the 8x16 glyph renderer (letter code, in-cell offsets,
// inside-rectangle flag). Four fixed messages are revealed with a
// typewriter effect, one character every CHAR_FRAMES frames.
//
// Handshake: there is no valid/ready pairing here. msgStart, msgClear and
// startOfFrame are single-cycle pulses sampled on the rising clk edge;
// msgClear beats msgStart, and msgStart beats startOfFrame (that frame is
// not counted). Outputs are registered, one cycle behind pixelX/pixelY.
//
// Optional feature: define TEXT_BLINK_EN to blink the finished line every
// BLINK_FRAMES frames while in SHOW. Without it SHOW is steady.
module text_line_driver #(
  parameter int TOP_LEFT_X   = 256,
  parameter int TOP_LEFT_Y   = 200,
  parameter int MAX_CHARS    = 12,
  parameter int CHAR_FRAMES  = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic [1:0]  msgSel,
  input  logic        msgStart,
  input  logic        msgClear,
  output logic [5:0]  letter,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TYPING = 2'd1,
    ST_SHOW   = 2'd2
  } state_t;

  localparam int LINE_W = MAX_CHARS * 8;
  localparam logic [7:0] CHAR_LAST = 8'(CHAR_FRAMES - 1);

  // Message ROM, one 6-bit glyph code per cell, cell 0 in the low bits.
  localparam logic [11:0][5:0] MSG0 = {6'd0, 6'd7, 6'd2, 6'd5, 6'd7, 6'd4,
                                       6'd0, 6'd4, 6'd4, 6'd3, 6'd2, 6'd1};
  localparam logic [11:0][5:0] MSG1 = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                                       6'd4, 6'd15, 6'd6, 6'd12, 6'd2, 6'd14};
  localparam logic [11:0][5:0] MSG2 = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9,
                                       6'd12, 6'd18, 6'd0, 6'd17, 6'd8, 6'd16};
  localparam logic [11:0][5:0] MSG3 = {6'd0, 6'd0, 6'd0, 6'd0, 6'd3, 6'd4,
                                       6'd8, 6'd19, 6'd0, 6'd17, 6'd8, 6'd16};

  // Reject configurations the counters cannot represent.
  if (CHAR_FRAMES < 1 || CHAR_FRAMES > 255 || BLINK_FRAMES < 1 ||
      BLINK_FRAMES > 255 || MAX_CHARS < 1 || MAX_CHARS > 15) begin : g_bad_param
    $error("text_line_driver: parameter out of range");
  end

  function automatic logic [3:0] msg_len(input logic [1:0] m);
    case (m)
      2'd0:    msg_len = 4'd11;
      2'd1:    msg_len = 4'd6;
      2'd2:    msg_len = 4'd7;
      default: msg_len = 4'd8;
    endcase
  endfunction

  function automatic logic [5:0] rom_char(input logic [1:0] m, input logic [3:0] i);
    logic [11:0][5:0] row;
    case (m)
      2'd0:    row = MSG0;
      2'd1:    row = MSG1;
      2'd2:    row = MSG2;
      default: row = MSG3;
    endcase
    rom_char = (i < 4'd12) ? row[i] : 6'd0;
  endfunction

  state_t      state;
  logic [1:0]  msg;
  logic [3:0]  reveal_cnt;
  logic [7:0]  frame_cnt;

  logic [10:0] dx;
  logic [10:0] dy;
  logic [7:0]  cell_idx;
  logic        in_line;
  logic        visible;
  logic        blink_on;

  assign state_dbg = state;

  // Scan geometry relative to the line's top-left corner.
  always_comb begin
    dx       = pixelX - 11'(TOP_LEFT_X);
    dy       = pixelY - 11'(TOP_LEFT_Y);
    cell_idx = dx[10:3];
    in_line  = (pixelX >= 11'(TOP_LEFT_X)) && (dx < 11'(LINE_W)) &&
               (pixelY >= 11'(TOP_LEFT_Y)) && (dy < 11'd16);
    visible  = in_line && (cell_idx < {4'b0, reveal_cnt}) && (state != ST_IDLE);
  end

  // Message FSM: commands first (clear over start), then frame counting.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      msg        <= 2'd0;
      reveal_cnt <= 4'd0;
      frame_cnt  <= 8'd0;
    end else if (msgClear) begin
      state      <= ST_IDLE;
      reveal_cnt <= 4'd0;
      frame_cnt  <= 8'd0;
    end else if (msgStart) begin
      state      <= ST_TYPING;
      msg        <= msgSel;
      reveal_cnt <= 4'd0;
      frame_cnt  <= 8'd0;
    end else if (state == ST_TYPING && startOfFrame) begin
      if (frame_cnt == CHAR_LAST) begin
        frame_cnt  <= 8'd0;
        reveal_cnt <= reveal_cnt + 4'd1;
        if ((reveal_cnt + 4'd1) == msg_len(msg)) begin
          state <= ST_SHOW;
        end
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef TEXT_BLINK_EN
  logic [7:0] blink_cnt;

  // Blink phase: forced on outside SHOW, toggles every BLINK_FRAMES frames in SHOW.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_on  <= 1'b1;
      blink_cnt <= 8'd0;
    end else if (state != ST_SHOW) begin
      blink_on  <= 1'b1;
      blink_cnt <= 8'd0;
    end else if (startOfFrame) begin
      if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt <= 8'd0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif

  // Registered glyph-renderer outputs, one cycle behind the scan position.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      letter          <= 6'd0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      InsideRectangle <= 1'b0;
    end else if (visible) begin
      letter          <= rom_char(msg, cell_idx[3:0]);
      offsetX         <= {8'd0, dx[2:0]};
      offsetY         <= {7'd0, dy[3:0]};
      InsideRectangle <= blink_on;
    end else begin
      letter          <= 6'd0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      InsideRectangle <= 1'b0;
    end
  end

  // Status flags follow the state register by one cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state == ST_TYPING);
      done <= (state == ST_SHOW);
    end
  end

endmodule

// File: tb/tb_text_line_driver.sv
// Bench for text_line_driver: scoreboard of expected renderer outputs built
// from a string-level model of the message line.
module tb_text_line_driver;

  localparam int CF = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [1:0]  msgSel;
  logic        msgStart;
  logic        msgClear;
  logic [5:0]  letter;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  logic [28:0] exp_q[$];
  int          tag_q[$];

  string msgs[4] = '{"PRESS START", "BRICKS", "YOU WIN", "YOU LOSE"};
  int    m_msg = 0;
  int    m_frames = 0;
  bit    m_active = 1'b0;

  text_line_driver dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .msgSel(msgSel), .msgStart(msgStart),
    .msgClear(msgClear), .letter(letter), .offsetX(offsetX), .offsetY(offsetY),
    .InsideRectangle(InsideRectangle), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic int code_of(byte c);
    case (c)
      "P": return 1;  "R": return 2;  "E": return 3;  "S": return 4;
      "A": return 5;  "C": return 6;  "T": return 7;  "O": return 8;
      "N": return 9;  "D": return 10; "M": return 11; "I": return 12;
      "Z": return 13; "B": return 14; "K": return 15; "Y": return 16;
      "U": return 17; "W": return 18; "L": return 19;
      default: return 0;
    endcase
  endfunction

  function automatic int model_rev();
    int len;
    int r;
    len = msgs[m_msg].len();
    r = m_frames / CF;
    return (r > len) ? len : r;
  endfunction

  function automatic logic [28:0] exp_pix(int x, int y);
    logic [28:0] r;
    string s;
    int i;
    r = '0;
    if (x >= 256 && x < 256 + 96 && y >= 200 && y < 216) begin
      i = (x - 256) / 8;
      if (m_active && i < model_rev()) begin
        s = msgs[m_msg];
        r = {1'b1, 6'(code_of(s[i])), 11'((x - 256) % 8), 11'((y - 200) % 16)};
      end
    end
    return r;
  endfunction

  // Scoreboard: compare the oldest pending expectation with current outputs.
  task automatic sb_check();
    logic [28:0] e;
    logic [28:0] a;
    int t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {InsideRectangle, letter, offsetX, offsetY};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL pixel x=%0d y=%0d got ins=%0b letter=%0d ox=%0d oy=%0d want ins=%0b letter=%0d ox=%0d oy=%0d",
                 t / 2048, t % 2048, a[28], a[27:22], a[21:11], a[10:0],
                 e[28], e[27:22], e[21:11], e[10:0]);
      end
    end
  endtask

  task automatic sb_drive(int x, int y);
    @(negedge clk);
    sb_check();
    pixelX = 11'(x);
    pixelY = 11'(y);
    exp_q.push_back(exp_pix(x, y));
    tag_q.push_back(x * 2048 + y);
  endtask

  task automatic sb_flush();
    @(negedge clk);
    sb_check();
  endtask

  task automatic probe_random(int n);
    for (int k = 0; k < n; k++) sb_drive($urandom_range(240, 370), $urandom_range(190, 225));
    sb_flush();
  endtask

  task automatic do_start(int sel);
    @(negedge clk);
    msgSel = 2'(sel);
    msgStart = 1'b1;
    @(negedge clk);
    msgStart = 1'b0;
    msgSel = 2'($urandom_range(0, 3));
    m_msg = sel;
    m_frames = 0;
    m_active = 1'b1;
  endtask

  task automatic frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    if (m_active) m_frames++;
  endtask

  task automatic frames(int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    pixelX = 11'd260;
    pixelY = 11'd205;
    startOfFrame = 1'b0;
    msgSel = 2'd0;
    msgStart = 1'b0;
    msgClear = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({InsideRectangle, letter, offsetX, offsetY} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {InsideRectangle, letter, offsetX, offsetY});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
    end
    resetN = 1'b1;
    for (int x = 248; x <= 360; x += 4) begin
      sb_drive(x, 199);
      sb_drive(x, 200);
      sb_drive(x, 215);
      sb_drive(x, 216);
    end
    sb_drive(0, 0);
    sb_drive(639, 479);
    sb_flush();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL idle_flags got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_typing();
    do_start(1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL typing_flags got busy=%b done=%b want 1 0", busy, done);
    end
    for (int f = 1; f <= 3; f++) begin
      frame();
      sb_drive(256, 200);
      sb_drive(263, 215);
      sb_flush();
    end
    frame();
    for (int x = 256; x <= 264; x++) begin
      sb_drive(x, 200);
      sb_drive(x, 215);
    end
    sb_flush();
    for (int f = 5; f <= 24; f++) begin
      frame();
      sb_drive(256 + 8 * ((f / CF) % 6) + (f % 8), 200 + f % 16);
      sb_drive(256 + 8 * (f / CF), 207);
      sb_flush();
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL show_flags got busy=%b done=%b want 0 1", busy, done);
    end
    for (int x = 296; x <= 304; x++) sb_drive(x, 210);
    sb_flush();
    @(negedge clk);
    pixelX = 11'd261;
    pixelY = 11'd203;
    @(negedge clk);
    checks++;
    if (letter !== 6'd14 || offsetX !== 11'd5 || offsetY !== 11'd3 || InsideRectangle !== 1'b1) begin
      failures++;
      $display("FAIL pix_261_203 got letter=%0d ox=%0d oy=%0d ins=%b want 14 5 3 1",
               letter, offsetX, offsetY, InsideRectangle);
    end
    pixelX = 11'd296;
    pixelY = 11'd200;
    @(negedge clk);
    checks++;
    if (letter !== 6'd4 || InsideRectangle !== 1'b1) begin
      failures++;
      $display("FAIL cell5_bricks got letter=%0d ins=%b want 4 1", letter, InsideRectangle);
    end
  endtask

  task automatic test_boundaries();
    do_start(0);
    frames(44);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL msg0_done got=%b want=1", done);
    end
    pixelX = 11'd255;
    pixelY = 11'd205;
    @(negedge clk);
    pixelX = 11'd352;
    checks++;
    if (InsideRectangle !== 1'b0) begin
      failures++;
      $display("FAIL left_edge got ins=%b want 0", InsideRectangle);
    end
    @(negedge clk);
    pixelX = 11'd296;
    checks++;
    if (InsideRectangle !== 1'b0) begin
      failures++;
      $display("FAIL right_edge got ins=%b want 0", InsideRectangle);
    end
    @(negedge clk);
    checks++;
    if (letter !== 6'd0 || InsideRectangle !== 1'b1) begin
      failures++;
      $display("FAIL space_cell got letter=%0d ins=%b want 0 1", letter, InsideRectangle);
    end
    sb_drive(255, 205);
    sb_drive(256, 205);
    sb_drive(343, 215);
    sb_drive(344, 205);
    sb_drive(351, 205);
    sb_drive(352, 205);
    sb_drive(300, 199);
    sb_drive(300, 216);
    sb_drive(2047, 2047);
    sb_flush();
    probe_random(40);
  endtask

  task automatic test_commands();
    do_start(0);
    frames(12);
    sb_drive(272, 204);
    sb_drive(280, 204);
    sb_flush();
    do_start(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL restart_busy got=%b want=1", busy);
      end
    end
    sb_drive(256, 200);
    sb_drive(270, 200);
    sb_flush();
    frames(4);
    sb_drive(259, 209);
    sb_drive(264, 209);
    sb_flush();
    // Start coinciding with a frame pulse: that frame must not count.
    frames(3);
    @(negedge clk);
    msgSel = 2'd3;
    msgStart = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    msgStart = 1'b0;
    startOfFrame = 1'b0;
    m_msg = 3;
    m_frames = 0;
    frames(3);
    sb_drive(258, 201);
    sb_flush();
    frame();
    sb_drive(258, 201);
    sb_flush();
    // Clear and start together: clear wins.
    @(negedge clk);
    msgSel = 2'd1;
    msgStart = 1'b1;
    msgClear = 1'b1;
    @(negedge clk);
    msgStart = 1'b0;
    msgClear = 1'b0;
    m_active = 1'b0;
    m_frames = 0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL clear_wins got busy=%b done=%b want 0 0", busy, done);
    end
    sb_drive(258, 201);
    sb_flush();
    frames(5);
    probe_random(20);
  endtask

  task automatic test_reset_mid();
    do_start(1);
    frames(6);
    sb_drive(258, 202);
    sb_flush();
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if ({InsideRectangle, letter, offsetX, offsetY, busy} !== 30'd0) begin
      failures++;
      $display("FAIL async_reset got ins=%b letter=%0d busy=%b want 0 0 0",
               InsideRectangle, letter, busy);
    end
    m_active = 1'b0;
    m_frames = 0;
    @(negedge clk);
    resetN = 1'b1;
    sb_drive(258, 202);
    sb_flush();
    do_start(1);
    frames(4);
    sb_drive(258, 202);
    sb_drive(266, 202);
    sb_flush();
  endtask

  task automatic test_back_to_back();
    do_start(3);
    frames(20);
    for (int k = 0; k < 200; k++) sb_drive($urandom_range(250, 360), $urandom_range(196, 220));
    for (int x = 250; x <= 360; x++) sb_drive(x, 210);
    sb_flush();
    frames(14);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL msg3_done got=%b want=1", done);
    end
    for (int k = 0; k < 100; k++) sb_drive($urandom_range(250, 360), $urandom_range(196, 220));
    sb_flush();
  endtask

  initial begin
    test_reset();
    test_typing();
    test_boundaries();
    test_commands();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
